uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
Far end of the serial link driven by the byte-level UART transmitter. It deserializes 8N1 frames on RX and assembles two consecutive bytes (high byte first) into a 16-bit command with a ready/clear handshake. It also serializes an 8-bit response back on TX. Both serial engines are internal, so a host UART pair can talk to the block directly.

Parameters:
BAUD_DIV, 2604, clock cycles per bit (50 MHz / 19200 baud); must be >= 8; benches use 16.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
RX  input  1  serial in, asynchronous, idle high
TX  output  1  serial out, idle high
cmd  output  16  last complete command {byte1, byte2}
cmd_rdy  output  1  complete command available
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  8  response byte, sampled on accepted send_resp
send_resp  input  1  request to transmit resp
tx_busy  output  1  response frame in progress
resp_sent  output  1  last response frame finished
frame_err  output  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frame_err=0. Byte pointer is set to the high byte. The RX synchronizer flops reset to 1.
- Reset mid-operation: both FSMs return to IDLE at the reset edge. Partial bytes are discarded. TX is 1 from the next edge.
- RX path: two-flop synchronizer, then falling-edge detect on the synchronized value. Baud counter counts 0..BAUD_DIV-1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge; the counter loads for BAUD_DIV/2 (integer division).
  - START: at half-bit, RX=0 -> DATA; RX=1 -> IDLE (glitch rejected, nothing logged).
  - DATA: samples every BAUD_DIV cycles, 8 samples, LSB first, shifted in from the MSB side.
  - STOP: samples after a further BAUD_DIV cycles. RX=1 -> byte valid. RX=0 -> frame_err pulses for 1 cycle, the byte is dropped and the pointer resets to the high byte. Either way the FSM returns to IDLE.
- Command assembly:
  - Valid byte with pointer=high: stored in the hold register; pointer -> low.
  - Valid byte with pointer=low: cmd <= {hold, byte} and cmd_rdy=1 on the clock after the stop sample; pointer -> high.
  - cmd holds its value until the next complete command.
- cmd_rdy clears on clr_cmd_rdy or on the validated start bit of the next high byte. If set and clear occur in the same cycle, set wins.
- Receive latency: cmd_rdy rises 2 (sync) + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the RX falling edge of the second byte, within ±1 cycle.
- TX FSM states: IDLE, XMIT.
  - send_resp in IDLE: loads {1, resp, 0} into a 10-bit shift register; tx_busy=1 and resp_sent=0 at the next edge; TX=0 from that edge.
  - Each bit is held exactly BAUD_DIV cycles, LSB first after the start bit.
  - After 10 bits: tx_busy=0, resp_sent=1 (level, held until the next accepted send_resp), TX=1.
- send_resp while tx_busy is ignored. resp is not resampled mid-frame.
- RX and TX are fully independent; simultaneous activity is legal, including loopback of TX to RX.

Test Plan:
- Drive RX frames 0xA5 then 0x3C (BAUD_DIV=16) -> cmd=16'hA53C, cmd_rdy=1, frame_err never 1. Pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd still 16'hA53C.
- resp=0xA5, pulse send_resp -> TX bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles. tx_busy is high for 160 cycles, then resp_sent=1. A second send_resp at cycle 50 is ignored, giving exactly one frame.
- Frame 0x12 with stop bit 0 -> one-cycle frame_err, cmd_rdy stays 0. Then frames 0x12, 0x34 -> cmd=16'h1234.
- RX low for 4 cycles, then high -> no frame_err, no cmd_rdy. Following frames 0x00, 0xFF -> cmd=16'h00FF.
- Loop TX to RX; send resp 0x5A, then 0xC3 after resp_sent -> cmd=16'h5AC3, cmd_rdy=1.
- Send high byte 0x77, assert rst for 1 cycle, then frames 0xBE, 0xEF -> cmd=16'hBEEF (not 16'h77BE). All outputs hold reset values during rst.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// 8N1 serial endpoint: receives two-byte commands (high byte first) with a ready/clear
// handshake, and transmits single response bytes back on TX.
module uart_cmd_responder #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frame_err
);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BitLast  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          byte_valid_q;
    logic [7:0]    hold_q;
    logic          ptr_low_q;
    logic          rx_fall, start_ok;

    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;

    assign rx_fall  = rx_prev_q & ~rx_sync_q;
    assign start_ok = (rx_state_q == RxStart) && (rx_cnt_q == HalfLast) && !rx_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_meta_q    <= RX;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err    <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    // Half-bit check rejects glitches shorter than half a bit
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                        if (rx_sync_q) byte_valid_q <= 1'b1;
                        else           frame_err    <= 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Command assembly; a later set of cmd_rdy overrides the clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            hold_q    <= '0;
            ptr_low_q <= 1'b0;
        end else begin
            if (clr_cmd_rdy || (start_ok && !ptr_low_q)) cmd_rdy <= 1'b0;
            if (frame_err) begin
                ptr_low_q <= 1'b0;
            end else if (byte_valid_q) begin
                if (ptr_low_q) begin
                    cmd       <= {hold_q, rx_shift_q};
                    cmd_rdy   <= 1'b1;
                    ptr_low_q <= 1'b0;
                end else begin
                    hold_q    <= rx_shift_q;
                    ptr_low_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            TX         <= 1'b1;
            tx_busy    <= 1'b0;
            resp_sent  <= 1'b0;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    if (send_resp) begin
                        tx_shift_q <= {1'b1, resp, 1'b0};
                        TX         <= 1'b0;
                        tx_busy    <= 1'b1;
                        resp_sent  <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TxXmit;
                    end
                end
                TxXmit: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_q <= TxIdle;
                            tx_busy    <= 1'b0;
                            resp_sent  <= 1'b1;
                            TX         <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                            TX         <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: table of two-byte commands plus hand-written
// sequences for framing errors, glitches, response transmit, loopback and mid-frame reset.
module tb_uart_cmd_responder;
    localparam int unsigned B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_busy, resp_sent, frame_err;

    assign rx_line = loop_en ? TX : rx_drv;

    uart_cmd_responder #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (rx_line),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, fe_cnt = 0, busy_cnt = 0, rise_cyc = 0;
    logic rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (tx_busy) busy_cnt <= busy_cnt + 1;
        if (cmd_rdy && !rdy_prev) rise_cyc <= cyc;
        rdy_prev <= cmd_rdy;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            tick(B);
        end
    endtask

    task automatic clr_pulse();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_pulse(input logic [7:0] r);
        resp = r;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        for (int i = 0; i < 400 && tx_busy; i++) tick(1);
        check(name, tx_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, TX, 1'b1);
        check({tag, "_cmd"}, cmd, 16'h0000);
        check({tag, "_cmd_rdy"}, cmd_rdy, 1'b0);
        check({tag, "_tx_busy"}, tx_busy, 1'b0);
        check({tag, "_resp_sent"}, resp_sent, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    initial begin
        int t_fall, lat, fe_before;
        logic [9:0] f;
        vecs[0] = '{hi: 8'hA5, lo: 8'h3C, exp: 16'hA53C};
        vecs[1] = '{hi: 8'h0F, lo: 8'hF0, exp: 16'h0FF0};
        vecs[2] = '{hi: 8'h80, lo: 8'h01, exp: 16'h8001};
        vecs[3] = '{hi: 8'hFF, lo: 8'h00, exp: 16'hFF00};

        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        for (int v = 0; v < 4; v++) begin
            rx_frame(vecs[v].hi, 1'b1);
            check($sformatf("v%0d_rdy_after_hi", v), cmd_rdy, 1'b0);
            t_fall = cyc;
            rx_frame(vecs[v].lo, 1'b1);
            tick(4);
            check($sformatf("v%0d_cmd", v), cmd, vecs[v].exp);
            check($sformatf("v%0d_rdy", v), cmd_rdy, 1'b1);
            lat = rise_cyc - t_fall;
            n_chk++;
            if (lat >= 154 && lat <= 156) n_pass++;
            else $display("FAIL v%0d_latency: got %0d required 155+-1", v, lat);
        end
        check("no_frame_err_clean", fe_cnt, 0);

        clr_pulse();
        check("clr_rdy", cmd_rdy, 1'b0);
        check("clr_cmd_hold", cmd, 16'hFF00);

        // Valid high byte, then a bad stop bit must drop it and rewind the pointer
        rx_frame(8'h55, 1'b1);
        rx_frame(8'h12, 1'b0);
        rx_drv = 1'b1;
        tick(20);
        check("fe_one_pulse", fe_cnt, 1);
        check("fe_rdy_low", cmd_rdy, 1'b0);
        rx_frame(8'h12, 1'b1);
        rx_frame(8'h34, 1'b1);
        tick(4);
        check("fe_recover_cmd", cmd, 16'h1234);
        check("fe_recover_rdy", cmd_rdy, 1'b1);

        clr_pulse();
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        check("glitch_no_fe", fe_cnt, 1);
        check("glitch_no_rdy", cmd_rdy, 1'b0);
        rx_frame(8'h00, 1'b1);
        rx_frame(8'hFF, 1'b1);
        tick(4);
        check("glitch_cmd", cmd, 16'h00FF);
        check("glitch_rdy", cmd_rdy, 1'b1);

        // Response frame; resp changes and a second request arrive mid-frame
        busy_cnt = 0;
        f = {1'b1, 8'hA5, 1'b0};
        send_pulse(8'hA5);
        for (int j = 0; j < 160; j++) begin
            if (j % 16 == 0 || j % 16 == 15)
                check($sformatf("tx_bit%0d_c%0d", j / 16, j % 16), TX, f[j / 16]);
            send_resp = (j == 50);
            if (j == 50) resp = 8'h00;
            tick(1);
        end
        send_resp = 1'b0;
        check("tx_done_busy", tx_busy, 1'b0);
        check("tx_done_sent", resp_sent, 1'b1);
        check("tx_done_line", TX, 1'b1);
        check("tx_busy_cycles", busy_cnt, 160);
        tick(200);
        check("tx_single_frame", busy_cnt, 160);
        check("tx_sent_held", resp_sent, 1'b1);

        clr_pulse();
        loop_en = 1'b1;
        send_pulse(8'h5A);
        check("loop_sent_cleared", resp_sent, 1'b0);
        wait_tx_done("loop_tx1_timeout");
        send_pulse(8'hC3);
        wait_tx_done("loop_tx2_timeout");
        tick(10);
        check("loop_cmd", cmd, 16'h5AC3);
        check("loop_rdy", cmd_rdy, 1'b1);
        loop_en = 1'b0;
        tick(5);

        clr_pulse();
        rx_frame(8'h77, 1'b1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick(5);
        fe_before = fe_cnt;
        rx_frame(8'hBE, 1'b1);
        rx_frame(8'hEF, 1'b1);
        tick(4);
        check("midrst_cmd", cmd, 16'hBEEF);
        check("midrst_rdy", cmd_rdy, 1'b1);
        check("midrst_no_fe", fe_cnt, fe_before);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
